// File: rtl/pulse_seq_ctrl.sv
// Spin-echo pulse-sequence scheduler: N shots of 90 / gap / 180 / gap / record / rep-delay, then done.
// Latency: all outputs registered; an accepted start shows acc_clr, busy and the first event one cycle later.
// Backpressure: none; start is a pulse honoured only in IDLE, abort overrides everything.
// Build option: define PHASE_CYCLE_EN to alternate the 90-degree pulse phase on every shot.
module pulse_seq_ctrl #(
    parameter int REP_W  = 16,
    parameter int SHOT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [4:0]        blank_lead,
    input  logic [7:0]        period90,
    input  logic [7:0]        pulse_gap,
    input  logic [7:0]        record_len,
    input  logic [REP_W-1:0]  rep_delay,
    input  logic [SHOT_W-1:0] num_shots,
    output logic [1:0]        tx,
    output logic              rx,
    output logic              u_blank,
    output logic              acc_clr,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [SHOT_W-1:0] shot_cnt
);

    // One down-counter serves every timed state; it must hold the 9-bit P180
    // length as well as the full repetition delay.
    localparam int CNT_W = (REP_W > 9) ? REP_W : 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE90,
        S_P90,
        S_GAP1,
        S_P180,
        S_GAP2,
        S_REC,
        S_REPDLY
    } state_t;

    typedef struct packed {
        logic [4:0]        blank;
        logic [7:0]        p90;
        logic [7:0]        gap;
        logic [7:0]        rec;
        logic [REP_W-1:0]  rep;
        logic [SHOT_W-1:0] shots;
    } cfg_t;

    state_t            state_q;
    state_t            state_d;
    state_t            shot_first;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    cfg_t              cfg_q;
    cfg_t              cfg_d;
    cfg_t              cfg_in;
    cfg_t              cfg_use;
    logic [SHOT_W-1:0] shot_d;

    logic [1:0]        tx_d;
    logic              rx_d;
    logic              u_blank_d;
    logic              acc_clr_d;
    logic              busy_d;
    logic              done_d;
    logic              cfg_err_d;

    logic              start_ok;
    logic              cnt_last;
    logic              entering;
    logic              leave_gap2;
    logic              leave_rec;
    logic              leave_rep;

    assign cfg_in = {blank_lead, period90, pulse_gap, record_len, rep_delay, num_shots};

    // Dwell time of each timed state, in clock cycles.
    function automatic logic [CNT_W-1:0] state_len(input state_t s, input cfg_t c);
        logic [CNT_W-1:0] len;
        len = '0;
        case (s)
            S_PRE90:  len = CNT_W'(c.blank);
            S_P90:    len = CNT_W'(c.p90);
            S_GAP1:   len = CNT_W'(c.gap);
            S_P180:   len = CNT_W'({c.p90, 1'b0});
            S_GAP2:   len = CNT_W'(c.gap);
            S_REC:    len = CNT_W'(c.rec);
            S_REPDLY: len = CNT_W'(c.rep);
            default:  len = '0;
        endcase
        return len;
    endfunction

    // Next state, counter reload, shot bookkeeping and next output values.
    always_comb begin
        // In IDLE the live inputs are about to be latched, so the first state
        // and its length are taken straight from them.
        cfg_use    = (state_q == S_IDLE) ? cfg_in : cfg_q;
        shot_first = (cfg_use.blank != 5'd0) ? S_PRE90 : S_P90;
        start_ok   = (period90 != 8'd0) && (num_shots != '0);
        cnt_last   = (cnt_q == CNT_W'(1));

        state_d    = state_q;
        cfg_d      = cfg_q;
        shot_d     = shot_cnt;
        acc_clr_d  = 1'b0;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        entering   = 1'b0;
        leave_gap2 = 1'b0;
        leave_rec  = 1'b0;
        leave_rep  = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                if (start_ok) begin
                    cfg_d     = cfg_in;
                    shot_d    = '0;
                    acc_clr_d = 1'b1;
                    state_d   = shot_first;
                    entering  = 1'b1;
                end else begin
                    cfg_err_d = 1'b1;
                end
            end
        end else if (cnt_last) begin
            entering = 1'b1;
            case (state_q)
                S_PRE90:  state_d = S_P90;
                S_P90:    state_d = (cfg_use.gap != 8'd0) ? S_GAP1 : S_P180;
                S_GAP1:   state_d = S_P180;
                S_P180: begin
                    if (cfg_use.gap != 8'd0) begin
                        state_d = S_GAP2;
                    end else begin
                        leave_gap2 = 1'b1;
                    end
                end
                S_GAP2:   leave_gap2 = 1'b1;
                S_REC:    leave_rec  = 1'b1;
                S_REPDLY: leave_rep  = 1'b1;
                default:  state_d    = S_IDLE;
            endcase

            // Zero-length states fall through to the next one in the same cycle.
            if (leave_gap2) begin
                if (cfg_use.rec != 8'd0) begin
                    state_d = S_REC;
                end else begin
                    leave_rec = 1'b1;
                end
            end

            // The record window closing is what completes a shot, even when it is empty.
            if (leave_rec) begin
                if (shot_cnt != cfg_use.shots) begin
                    shot_d = shot_cnt + SHOT_W'(1);
                end
                if (cfg_use.rep != '0) begin
                    state_d = S_REPDLY;
                end else begin
                    leave_rep = 1'b1;
                end
            end

            if (leave_rep) begin
                if (shot_d == cfg_use.shots) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = shot_first;
                end
            end
        end

        cnt_d = entering ? state_len(state_d, cfg_use) : (cnt_q - CNT_W'(1));
        if (state_d == S_IDLE) begin
            cnt_d = '0;
        end

        tx_d = 2'b00;
        if (state_d == S_P90) begin
`ifdef PHASE_CYCLE_EN
            // Two-step phase cycle: even shots at 0 deg, odd shots at 180 deg.
            tx_d = shot_d[0] ? 2'b10 : 2'b01;
`else
            tx_d = 2'b01;
`endif
        end else if (state_d == S_P180) begin
            tx_d = 2'b01;
        end

        rx_d = (state_d == S_REC);

        // During GAP1 the counter holds the cycles left, so the lead before the
        // 180 pulse is simply "cycles left <= blank_lead".
        u_blank_d = (state_d == S_PRE90) || (state_d == S_P90) || (state_d == S_P180) ||
                    ((state_d == S_GAP1) && (cnt_d <= CNT_W'(cfg_use.blank)));

        busy_d = (state_d != S_IDLE);
    end

    // Sequencer state, dwell counter, latched configuration and shot count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cfg_q    <= '0;
            shot_cnt <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cfg_q    <= cfg_d;
            shot_cnt <= shot_d;
        end
    end

    // Registered gate/window/status outputs; reset drops the gates immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx      <= 2'b00;
            rx      <= 1'b0;
            u_blank <= 1'b0;
            acc_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            tx      <= tx_d;
            rx      <= rx_d;
            u_blank <= u_blank_d;
            acc_clr <= acc_clr_d;
            busy    <= busy_d;
            done    <= done_d;
            cfg_err <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Bench for pulse_seq_ctrl: per-cycle output timeline predicted from the sequence rules.
// Latency: expects the first event one cycle after the start edge.
// Backpressure: none; inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_pulse_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  blank_lead;
    logic [7:0]  period90;
    logic [7:0]  pulse_gap;
    logic [7:0]  record_len;
    logic [15:0] rep_delay;
    logic [7:0]  num_shots;
    logic [1:0]  tx;
    logic        rx;
    logic        u_blank;
    logic        acc_clr;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [7:0]  shot_cnt;

    always #5 clk = ~clk;

    pulse_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .blank_lead (blank_lead),
        .period90   (period90),
        .pulse_gap  (pulse_gap),
        .record_len (record_len),
        .rep_delay  (rep_delay),
        .num_shots  (num_shots),
        .tx         (tx),
        .rx         (rx),
        .u_blank    (u_blank),
        .acc_clr    (acc_clr),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .shot_cnt   (shot_cnt)
    );

    // {tx, rx, u_blank, acc_clr, busy, done, cfg_err, shot_cnt}
    logic [15:0] obs;
    assign obs = {tx, rx, u_blank, acc_clr, busy, done, cfg_err, shot_cnt};

    int          n_checks = 0;
    int          n_fail   = 0;
    int          last_sc  = 0;
    logic [15:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pk(input int t, input int r, input int ub, input int ac,
                                       input int bz, input int dn, input int ce, input int sc);
        return {2'(t), 1'(r), 1'(ub), 1'(ac), 1'(bz), 1'(dn), 1'(ce), 8'(sc)};
    endfunction

    function automatic int p90_phase(input int k);
`ifdef PHASE_CYCLE_EN
        return (k % 2 == 1) ? 2 : 1;
`else
        return (k >= 0) ? 1 : 1;
`endif
    endfunction

    // Expected output of every cycle of a run, from the first event through the done cycle.
    task automatic build_model(input int b, input int p, input int g, input int r,
                               input int rp, input int s);
        logic [15:0] first;
        int          lead;
        exp_q.delete();
        lead = (b < g) ? b : g;
        for (int k = 0; k < s; k++) begin
            for (int c = 0; c < b; c++)      exp_q.push_back(pk(0, 0, 1, 0, 1, 0, 0, k));
            for (int c = 0; c < p; c++)      exp_q.push_back(pk(p90_phase(k), 0, 1, 0, 1, 0, 0, k));
            for (int c = 0; c < g; c++)      exp_q.push_back(pk(0, 0, (c >= g - lead) ? 1 : 0, 0, 1, 0, 0, k));
            for (int c = 0; c < 2 * p; c++)  exp_q.push_back(pk(1, 0, 1, 0, 1, 0, 0, k));
            for (int c = 0; c < g; c++)      exp_q.push_back(pk(0, 0, 0, 0, 1, 0, 0, k));
            for (int c = 0; c < r; c++)      exp_q.push_back(pk(0, 1, 0, 0, 1, 0, 0, k));
            for (int c = 0; c < rp; c++)     exp_q.push_back(pk(0, 0, 0, 0, 1, 0, 0, k + 1));
        end
        exp_q.push_back(pk(0, 0, 0, 0, 0, 1, 0, s));
        first     = exp_q[0];
        first[11] = 1'b1;
        exp_q[0]  = first;
    endtask

    task automatic scramble_cfg();
        blank_lead = 5'($urandom);
        period90   = 8'($urandom);
        pulse_gap  = 8'($urandom);
        record_len = 8'($urandom);
        rep_delay  = 16'($urandom);
        num_shots  = 8'($urandom);
    endtask

    // Called just after a falling edge with start low. Config inputs are scrambled
    // every cycle of the run, since the latched copy must be used.
    task automatic run_seq(input int b, input int p, input int g, input int r, input int rp,
                           input int s, input int abort_at, input int rst_at,
                           input int mid_start_at, input string name);
        int sc_hold;
        build_model(b, p, g, r, rp, s);
        blank_lead = 5'(b);
        period90   = 8'(p);
        pulse_gap  = 8'(g);
        record_len = 8'(r);
        rep_delay  = 16'(rp);
        num_shots  = 8'(s);
        start      = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            start = 1'b0;
            scramble_cfg();
            check_val($sformatf("%s_c%0d", name, i), 32'(obs), 32'(exp_q[i]));
            if (i == abort_at) begin
                sc_hold = int'(exp_q[i][7:0]);
                abort   = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check_val($sformatf("%s_abort", name), 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0, 0, sc_hold)));
                @(negedge clk);
                check_val($sformatf("%s_abort_nodone", name), 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0, 0, sc_hold)));
                last_sc = sc_hold;
                return;
            end
            if (i == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_val($sformatf("%s_rst_async", name), 32'({tx, rx, u_blank}), 32'd0);
                @(negedge clk);
                check_val($sformatf("%s_rst_hold", name), 32'(obs), 32'd0);
                rst_n = 1'b1;
                @(negedge clk);
                check_val($sformatf("%s_rst_idle", name), 32'(obs), 32'd0);
                last_sc = 0;
                return;
            end
            if (i == mid_start_at && i < exp_q.size() - 1) begin
                start = 1'b1;
            end
        end
        @(negedge clk);
        check_val($sformatf("%s_idle", name), 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0, 0, s)));
        last_sc = s;
    endtask

    task automatic reject(input int p, input int s, input string name);
        scramble_cfg();
        period90  = 8'(p);
        num_shots = 8'(s);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val($sformatf("%s_err", name), 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0, 1, last_sc)));
        @(negedge clk);
        check_val($sformatf("%s_after", name), 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0, 0, last_sc)));
    endtask

    task automatic start_with_abort();
        blank_lead = 5'd2;
        period90   = 8'd4;
        pulse_gap  = 8'd3;
        record_len = 8'd3;
        rep_delay  = 16'd2;
        num_shots  = 8'd1;
        start      = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_val("start_abort_same", 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0, 0, last_sc)));
        @(negedge clk);
        check_val("start_abort_stays", 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0, 0, last_sc)));
    endtask

    initial begin
        int b, p, g, r, rp, s;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        blank_lead = '0;
        period90   = '0;
        pulse_gap  = '0;
        record_len = '0;
        rep_delay  = '0;
        num_shots  = '0;
        repeat (3) @(negedge clk);
        check_val("reset_state", 32'(obs), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_after_reset", 32'(obs), 32'd0);

        run_seq(2, 10, 50, 100, 20, 1, -1, -1, -1, "basic");
        run_seq(3, 4, 6, 8, 5, 3, -1, -1, 5, "three_shots");
        reject(0, 2, "rej_p90");
        reject(5, 0, "rej_shots");
        reject(0, 0, "rej_both");
        run_seq(3, 6, 5, 10, 4, 2, 20, -1, -1, "abort_p180");
        start_with_abort();
        run_seq(1, 3, 2, 4, 2, 1, -1, -1, -1, "restart");
        run_seq(31, 3, 8, 0, 3, 2, -1, -1, -1, "long_lead");
        run_seq(0, 2, 0, 0, 0, 3, -1, -1, 1, "back_to_back");
        run_seq(2, 3, 4, 10, 5, 2, -1, 23, -1, "rst_rec");
        run_seq(1, 2, 3, 2, 1, 1, -1, -1, -1, "after_rst");

        for (int n = 0; n < 25; n++) begin
            b  = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 6));
            p  = int'($urandom_range(1, 6));
            g  = int'($urandom_range(0, 8));
            r  = int'($urandom_range(0, 10));
            rp = int'($urandom_range(0, 6));
            s  = int'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) begin
                run_seq(b, p, g, r, rp, s, b + p + g + 1, -1, -1, $sformatf("rnd%0d", n));
            end else begin
                run_seq(b, p, g, r, rp, s, -1, -1, int'($urandom_range(0, 60)), $sformatf("rnd%0d", n));
            end
            if ($urandom_range(0, 3) == 0) begin
                reject(0, int'($urandom_range(0, 3)), $sformatf("rnd_rej%0d", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
